// File: rtl/fc_output_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fc_output_serializer
// Purpose  : Ping-pong buffered FC-layer output stage; optional ReLU, then
//            streams each captured vector to an output FIFO in LANES-word beats.
// Revision : 1.0
// ============================================================================
module fc_output_serializer #(
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16,
    parameter int LANES        = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic                                   relu_i,
    input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    output logic                                   wen_o,
    input  logic                                   full_i,
    output logic [LANES-1:0][WORD_SIZE-1:0]        data_o,
    output logic [LANES-1:0]                       keep_o,
    output logic                                   last_o,
    output logic [1:0]                             pending_o
);

    localparam int NUM_BEATS  = (LAYER_HEIGHT + LANES - 1) / LANES;
    localparam int BW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int BEAT_SLOTS = 1 << BW;
    localparam int PAD_WORDS  = NUM_BEATS * LANES;
    localparam logic [BW-1:0] C_LAST_BEAT = BW'(NUM_BEATS - 1);

    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_slot [2];
    logic [1:0]                             r_v;
    logic                                   r_wr_sel;
    logic                                   r_rd_sel;
    logic [BW-1:0]                          r_beat;

    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] w_cap_data;
    logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] w_rd_vec;
    logic [PAD_WORDS-1:0][WORD_SIZE-1:0]    w_pad;
    logic [LANES-1:0][WORD_SIZE-1:0]        w_beat_data [BEAT_SLOTS];
    logic [LANES-1:0]                       w_beat_keep [BEAT_SLOTS];
    logic                                   w_capture;
    logic                                   w_rd_valid;
    logic                                   w_drain;
    logic                                   w_last_beat;
    logic [1:0]                             w_v_next;

    genvar gj, gb, gk;

    generate
        for (gj = 0; gj < LAYER_HEIGHT; gj++) begin : g_relu
            assign w_cap_data[gj] = (relu_i && data_i[gj][WORD_SIZE-1]) ? '0 : data_i[gj];
        end
    endgenerate

    // Pad the read vector to a whole number of beats so the tail lanes read 0.
    assign w_rd_vec = r_slot[r_rd_sel];

    generate
        for (gj = 0; gj < PAD_WORDS; gj++) begin : g_pad
            if (gj < LAYER_HEIGHT) begin : g_word
                assign w_pad[gj] = w_rd_vec[gj];
            end else begin : g_zero
                assign w_pad[gj] = '0;
            end
        end
    endgenerate

    generate
        for (gb = 0; gb < BEAT_SLOTS; gb++) begin : g_beat
            if (gb < NUM_BEATS) begin : g_live
                assign w_beat_data[gb] = w_pad[gb*LANES +: LANES];
                for (gk = 0; gk < LANES; gk++) begin : g_keep
                    assign w_beat_keep[gb][gk] = ((gb * LANES + gk) < LAYER_HEIGHT);
                end
            end else begin : g_dead
                assign w_beat_data[gb] = '0;
                assign w_beat_keep[gb] = '0;
            end
        end
    endgenerate

    assign ready_o     = ~r_v[r_wr_sel];
    assign w_capture   = valid_i & ~r_v[r_wr_sel];
    assign w_rd_valid  = r_v[r_rd_sel];
    assign w_drain     = w_rd_valid & ~full_i;
    assign w_last_beat = (r_beat == C_LAST_BEAT);

    // Capture and final-beat free always target different slots, so both apply.
    always_comb begin
        w_v_next = r_v;
        if (w_capture) begin
            w_v_next[r_wr_sel] = 1'b1;
        end
        if (w_drain && w_last_beat) begin
            w_v_next[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_v       <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_beat    <= '0;
        end else begin
            r_v <= w_v_next;
            if (w_capture) begin
                r_slot[r_wr_sel] <= w_cap_data;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_drain) begin
                if (w_last_beat) begin
                    r_beat   <= '0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_beat <= r_beat + BW'(1);
                end
            end
        end
    end

    assign wen_o     = w_drain;
    assign data_o    = w_rd_valid ? w_beat_data[r_beat] : '0;
    assign keep_o    = w_rd_valid ? w_beat_keep[r_beat] : '0;
    assign last_o    = w_rd_valid & w_last_beat;
    assign pending_o = {1'b0, r_v[0]} + {1'b0, r_v[1]};

endmodule
`default_nettype wire

// File: doc/fc_output_serializer.md
Name: fc_output_serializer

Overview:
- Next-generation output stage of a fully-connected layer: captures one LAYER_HEIGHT-word result vector per valid/ready handshake.
- Optionally applies ReLU per vector, then writes the vector into the downstream output FIFO in LANES-word beats.
- Two-slot (ping-pong) buffer: a new vector is accepted while the previous one drains, sustaining one vector per ceil(LAYER_HEIGHT/LANES) cycles.

Parameters:
- LAYER_HEIGHT, 5, words per input vector (>=1).
- WORD_SIZE, 16, bits per word, two's complement.
- LANES, 1, words per output beat (1..LAYER_HEIGHT). LAYER_HEIGHT need not be a multiple of LANES.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  upstream vector valid.
- ready_o  output  1  block can accept a vector this cycle.
- relu_i  input  1  apply ReLU to this vector; sampled with data_i on handshake.
- data_i  input  [LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  input vector; word 0 is emitted first.
- wen_o  output  1  FIFO write enable.
- full_i  input  1  FIFO full.
- data_o  output  [LANES-1:0][WORD_SIZE-1:0]  output beat; lane 0 = lowest word index.
- keep_o  output  LANES  per-lane valid mask for the current beat.
- last_o  output  1  current beat is the final beat of its vector.
- pending_o  output  2  number of buffered vectors not yet fully written (0..2).

Behaviour:
- Definitions: NUM_BEATS = ceil(LAYER_HEIGHT/LANES). The beat counter is max(1,$clog2(NUM_BEATS)) bits wide.
- State:
  - two slots, each holding a vector and an occupied bit v[0..1];
  - wr_sel and rd_sel, 1-bit slot pointers;
  - beat, the beat counter.
- Reset (asynchronous, reset_i=1): v=0, wr_sel=0, rd_sel=0, beat=0, slot data=0. Outputs during and after reset: ready_o=1, wen_o=0, data_o=0, keep_o=0, last_o=0, pending_o=0.
- ready_o = ~v[wr_sel]. It is a function of registered state only; there is no combinational path from valid_i or full_i.
- Capture (valid_i && ready_o at edge):
  - slot[wr_sel] <= data_i, with each word negative (MSB=1) replaced by 0 when relu_i=1, otherwise unchanged;
  - v[wr_sel] <= 1; wr_sel toggles.
  - A data_i held without valid_i is ignored.
- Drain: wen_o = v[rd_sel] && ~full_i. When wen_o=1 at an edge:
  - if beat != NUM_BEATS-1, beat increments;
  - if beat == NUM_BEATS-1, v[rd_sel] <= 0, rd_sel toggles, beat <= 0.
- full_i=1 stalls. beat, data_o, keep_o and last_o stay stable; wen_o=0.
- Output beat, when v[rd_sel]=1:
  - data_o lane k = slot[rd_sel] word (beat*LANES+k).
  - Lanes with index >= LAYER_HEIGHT read 0 and have keep_o[k]=0; all other lanes have keep_o[k]=1.
  - last_o = (beat == NUM_BEATS-1).
- When v[rd_sel]=0: data_o=0, keep_o=0, last_o=0.
- Latency: a vector captured at edge N can produce its first wen_o in the cycle following edge N.
- Simultaneous capture into one slot and final-beat free of the other slot in the same edge is legal; both take effect.
- A slot freed at edge N makes ready_o=1 in the cycle after edge N, not combinationally in the same cycle.
- pending_o = v[0] + v[1].
- Throughput: with full_i=0 and valid_i held high, wen_o stays continuously high after the first capture, including LANES=LAYER_HEIGHT (one vector per cycle).
- Vectors are emitted strictly in acceptance order; a second vector never interleaves with the first.
- Reset mid-vector: every buffered and partially written vector is discarded. No further wen_o occurs until a new capture.

Test Plan:
- LAYER_HEIGHT=5, LANES=1, relu_i=0, data_i={5,-1,3,0,7} (word0=7), full_i=0 -> wen_o high 5 consecutive cycles starting the cycle after capture, with data_o 7,0,3,-1,5. last_o only on the 5th beat; ready_o stays 1 (second slot free).
- LAYER_HEIGHT=5, LANES=2, relu_i=1, words 0..4 = {-4,9,-1,2,6} -> beats {0,9} keep 11; {0,2} keep 11; {6,0} keep 01 with last_o=1.
- Back-to-back vectors A,B,C, valid_i held high, LANES=1, full_i=0 -> A and B accepted in the first two cycles, then ready_o=0 until A's last beat. C is accepted the cycle after that. The output stream is gap-free: A0..A4,B0..B4,C0..C4.
- full_i toggled 1,0,1,1,0 mid-vector -> wen_o low on every full_i=1 cycle. data_o holds its value across the stall. No beats are dropped or duplicated; order is preserved.
- LANES=LAYER_HEIGHT=5, valid_i high for 4 cycles -> wen_o high for 4 consecutive cycles with last_o=1 each; pending_o never exceeds 1.
- Reset asserted asynchronously mid-vector with pending_o=2 -> outputs immediately ready_o=1, wen_o=0, pending_o=0. After release, a new vector drains from word 0.
